// File: rtl/apo_noc_pkg.sv
// Shared constants for the circulant NoC router slice.
// Port indices, packet geometry and round-robin helper.
package apo_noc_pkg;

  localparam int K         = 6;
  localparam int N         = 7;
  localparam int N2        = 13;
  localparam int VALID_BIT = N2 - 1;
  localparam int NUM_PORTS = 5;
  localparam int CNT_W     = 16;

  localparam logic [2:0] P_FREE = 3'd0;
  localparam logic [2:0] P_R1R  = 3'd1;
  localparam logic [2:0] P_R2R  = 3'd2;
  localparam logic [2:0] P_R1L  = 3'd3;
  localparam logic [2:0] P_R2L  = 3'd4;

  // (a + b) mod NUM_PORTS for operands already below NUM_PORTS
  function automatic logic [2:0] port_add(
    input logic [2:0] a,
    input logic [2:0] b
  );
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'(NUM_PORTS)) s = s - 4'(NUM_PORTS);
    return s[2:0];
  endfunction

endpackage

// File: rtl/apo_pkt_fifo.sv
// Per-port packet FIFO with pop-then-push on full.
// A push into a full FIFO without a same-edge pop is dropped.
module apo_pkt_fifo
  import apo_noc_pkg::*;
#(
  parameter int PKT_W = N2,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [PKT_W-1:0] din_i,
  input  logic             pop_i,
  output logic [PKT_W-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W:0]   cnt_q;
  logic [PTR_W:0]   cnt_d;
  logic             do_pop;
  logic             do_push;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;
  assign dout_o  = mem_q[rd_q];

  // occupancy next state
  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // pointers and count; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push) wr_q <= wr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // storage; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/apo_input_arbiter.sv
// Input buffering and registered round-robin arbiter.
// Optional stats counters under APO_ARB_STATS_EN.
module apo_input_arbiter
  import apo_noc_pkg::*;
#(
  parameter int PKT_W = N2,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PKT_W-1:0]       in_free,
  input  logic [PKT_W-1:0]       in_r1R,
  input  logic [PKT_W-1:0]       in_r2R,
  input  logic [PKT_W-1:0]       in_r1L,
  input  logic [PKT_W-1:0]       in_r2L,
  output logic [PKT_W-1:0]       out_pkt,
  output logic [2:0]             out_src,
  output logic                   out_inph,
  output logic [NUM_PORTS-1:0]   fifo_full,
  output logic [NUM_PORTS-1:0]   ovf_pulse
`ifdef APO_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0]           fwd_cnt
`endif
);

  logic [PKT_W-1:0]     in_w [NUM_PORTS];
  logic [PKT_W-1:0]     dout [NUM_PORTS];
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] drop;
  logic [NUM_PORTS-1:0] pop;
  logic [2:0]           rr_q;
  logic [2:0]           rr_d;
  logic [2:0]           sel;
  logic [2:0]           idx;
  logic                 hit;

  assign in_w[P_FREE] = in_free;
  assign in_w[P_R1R]  = in_r1R;
  assign in_w[P_R2R]  = in_r2R;
  assign in_w[P_R1L]  = in_r1L;
  assign in_w[P_R2L]  = in_r2L;

  assign fifo_full = full;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
    apo_pkt_fifo #(
      .PKT_W (PKT_W),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (in_w[i][PKT_W-1]),
      .din_i   (in_w[i]),
      .pop_i   (pop[i]),
      .dout_o  (dout[i]),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .drop_o  (drop[i])
    );
  end

  // first non-empty port scanning upward from rr_q
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = port_add(rr_q, 3'(k));
      if (!hit && !empty[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end

  // pop strobe and pointer advance for the winner
  always_comb begin
    pop  = '0;
    rr_d = rr_q;
    if (hit) begin
      pop[sel] = 1'b1;
      rr_d     = port_add(sel, 3'd1);
    end
  end

  // output registers, pointer and drop pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= '0;
      out_pkt   <= '0;
      out_src   <= '0;
      out_inph  <= 1'b0;
      ovf_pulse <= '0;
    end else begin
      rr_q      <= rr_d;
      out_pkt   <= hit ? dout[sel] : '0;
      out_src   <= hit ? sel : 3'd0;
      out_inph  <= hit && (sel != P_FREE);
      ovf_pulse <= drop;
    end
  end

`ifdef APO_ARB_STATS_EN
  // saturating drop and forward counters
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      fwd_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (drop[i] && drop_cnt[i*CNT_W +: CNT_W] != '1)
          drop_cnt[i*CNT_W +: CNT_W] <= drop_cnt[i*CNT_W +: CNT_W] + 1'b1;
      end
      if (hit && fwd_cnt != '1) fwd_cnt <= fwd_cnt + 1'b1;
    end
  end
`endif

endmodule
